// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer: FP opcodes, FSM states,
// the +0.0 constant and a helper for locating element i inside a packed vector.
// Optional feature macro used by the sequencer: SOFTMAX_MAX_SUBTRACT_EN.
package softmax_pkg;

  // Opcodes understood by the shared floating-point unit
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_DIV = 2'b01,
    OP_EXP = 2'b10
  } fp_op_e;

  // Sequencer states; MAX is only visited when max-subtraction is built in
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAX,
    EXP,
    SUM,
    DIV,
    DONE
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Bit offset of element idx in a vector packed as [idx*width +: width]
  function automatic int elem_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fp_max_compare.sv
// Combinational IEEE-754 "a > b" compare in sign-magnitude form; +0 and -0 are equal.
// Ports: i_a, i_b operands; o_gt high when i_a is strictly greater than i_b.
// Only instantiated when SOFTMAX_MAX_SUBTRACT_EN is defined.
module fp_max_compare
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_b,
  output logic                 o_gt
);

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [DATAWIDTH-2:0] w_mag_a;
  logic [DATAWIDTH-2:0] w_mag_b;
  logic                 w_both_zero;

  assign w_a_neg     = i_a[DATAWIDTH-1];
  assign w_b_neg     = i_b[DATAWIDTH-1];
  assign w_mag_a     = i_a[DATAWIDTH-2:0];
  assign w_mag_b     = i_b[DATAWIDTH-2:0];
  assign w_both_zero = (w_mag_a == '0) && (w_mag_b == '0);

  always_comb begin
    o_gt = 1'b0;
    if (w_both_zero) begin
      o_gt = 1'b0;
    end else if (w_a_neg != w_b_neg) begin
      // Differing signs: a wins exactly when b is the negative one
      o_gt = w_b_neg;
    end else if (!w_a_neg) begin
      o_gt = (w_mag_a > w_mag_b);
    end else begin
      // Both negative: smaller magnitude is the larger value
      o_gt = (w_mag_a < w_mag_b);
    end
  end

endmodule

// File: rtl/softmax_sequencer.sv
// Softmax controller: latches N float32 logits, drives one shared FP unit
// (EXP/ADD/DIV, one outstanding op) through exp, accumulate and divide phases.
// Ports: clock/reset (sync, active-high); start/in_vec job request; busy/done/out_vec
// job status and probabilities; op_valid/op_ready/op_code/op_a/op_b request channel;
// res_valid/res_data result strobe. Macro SOFTMAX_MAX_SUBTRACT_EN adds a max scan
// and subtracts the maximum before each exp for numerical stability.
module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int N         = 10,
  parameter int IDXW      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N*DATAWIDTH-1:0] in_vec,
  output logic                   busy,
  output logic                   done,
  output logic [N*DATAWIDTH-1:0] out_vec,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [1:0]             op_code,
  output logic [DATAWIDTH-1:0]   op_a,
  output logic [DATAWIDTH-1:0]   op_b,
  input  logic                   res_valid,
  input  logic [DATAWIDTH-1:0]   res_data
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_op_valid;
  logic                   r_wait;      // request accepted, result not yet returned
  logic [1:0]             r_op_code;
  logic [DATAWIDTH-1:0]   r_op_a;
  logic [DATAWIDTH-1:0]   r_op_b;
  logic [DATAWIDTH-1:0]   r_acc;
  logic [IDXW-1:0]        r_idx;
  logic [N*DATAWIDTH-1:0] r_out_vec;
  logic [DATAWIDTH-1:0]   r_x [N];
  logic [DATAWIDTH-1:0]   r_e [N];

  logic                   w_op_phase;
  logic                   w_issue;
  logic                   w_last;
  fp_op_e                 w_code;
  logic [DATAWIDTH-1:0]   w_a;
  logic [DATAWIDTH-1:0]   w_b;

`ifdef SOFTMAX_MAX_SUBTRACT_EN
  logic [DATAWIDTH-1:0]   r_mx;
  logic                   r_sub_done;  // ADD(x,-mx) finished for this idx, EXP pending
  logic                   w_gt;

  fp_max_compare #(
    .DATAWIDTH (DATAWIDTH)
  ) u_max_cmp (
    .i_a  (r_x[r_idx]),
    .i_b  (r_mx),
    .o_gt (w_gt)
  );
`endif

  assign w_op_phase = (r_state == EXP) || (r_state == SUM) || (r_state == DIV);
  // A new request goes out only once the previous one has fully completed
  assign w_issue    = w_op_phase && !r_op_valid && !r_wait;
  assign w_last     = (r_idx == LAST_IDX);

  // Operand selection for the request about to be issued
  always_comb begin
    w_code = OP_ADD;
    w_a    = r_acc;
    w_b    = r_e[r_idx];
    case (r_state)
      EXP: begin
`ifdef SOFTMAX_MAX_SUBTRACT_EN
        if (r_sub_done) begin
          w_code = OP_EXP;
          w_a    = r_e[r_idx];
          w_b    = DATAWIDTH'(FP_ZERO);
        end else begin
          w_code = OP_ADD;
          w_a    = r_x[r_idx];
          w_b    = {~r_mx[DATAWIDTH-1], r_mx[DATAWIDTH-2:0]};
        end
`else
        w_code = OP_EXP;
        w_a    = r_x[r_idx];
        w_b    = DATAWIDTH'(FP_ZERO);
`endif
      end
      DIV: begin
        w_code = OP_DIV;
        w_a    = r_e[r_idx];
        w_b    = r_acc;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_op_valid <= 1'b0;
      r_wait     <= 1'b0;
      r_op_code  <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_out_vec  <= '0;
`ifdef SOFTMAX_MAX_SUBTRACT_EN
      r_mx       <= '0;
      r_sub_done <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      if (r_op_valid && op_ready) begin
        r_op_valid <= 1'b0;
        r_wait     <= 1'b1;
      end

      if (w_issue) begin
        r_op_valid <= 1'b1;
        r_op_code  <= w_code;
        r_op_a     <= w_a;
        r_op_b     <= w_b;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end

        LOAD: begin
          for (int i = 0; i < N; i++) begin
            r_x[i] <= in_vec[elem_lsb(i, DATAWIDTH) +: DATAWIDTH];
          end
          r_idx <= '0;
          r_acc <= DATAWIDTH'(FP_ZERO);
`ifdef SOFTMAX_MAX_SUBTRACT_EN
          r_state <= MAX;
`else
          r_state <= EXP;
`endif
        end

        MAX: begin
`ifdef SOFTMAX_MAX_SUBTRACT_EN
          // Element 0 seeds the running maximum
          if ((r_idx == '0) || w_gt) begin
            r_mx <= r_x[r_idx];
          end
          if (w_last) begin
            r_idx   <= '0;
            r_state <= EXP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
`else
          r_state <= IDLE;
`endif
        end

        EXP, SUM, DIV: begin
          // Strobes arriving while no op is outstanding never reach here
          if (r_wait && res_valid) begin
            r_wait <= 1'b0;
            if (r_state == EXP) begin
              r_e[r_idx] <= res_data;
`ifdef SOFTMAX_MAX_SUBTRACT_EN
              r_sub_done <= !r_sub_done;
              if (r_sub_done) begin
                if (w_last) begin
                  r_idx   <= '0;
                  r_state <= SUM;
                end else begin
                  r_idx <= r_idx + 1'b1;
                end
              end
`else
              if (w_last) begin
                r_idx   <= '0;
                r_state <= SUM;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
`endif
            end else if (r_state == SUM) begin
              r_acc <= res_data;
              if (w_last) begin
                r_idx   <= '0;
                r_state <= DIV;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_out_vec[elem_lsb(int'(r_idx), DATAWIDTH) +: DATAWIDTH] <= res_data;
              if (w_last) begin
                r_idx   <= '0;
                r_state <= DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out_vec  = r_out_vec;
  assign op_valid = r_op_valid;
  assign op_code  = r_op_code;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;

endmodule
